// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side controller.
// Data width default and reader state encoding.
package fifo_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_reader_if.sv
// Output stream bundle of the FIFO reader.
// The master drives data/valid/last; the slave drives ready.
interface fifo_reader_if
  import fifo_pkg::*;
#(
  parameter int DW = DATA_WIDTH
);

  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/stream_skid_buffer.sv
// Two-entry {data, last} buffer; entry 0 is always the head.
// Absorbs the one-cycle FIFO read latency.
module stream_skid_buffer
  import fifo_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          head_last,
  output logic [1:0]    count
);

  logic [DW-1:0] d0, d1;
  logic          l0, l1;

  assign head_data = d0;
  assign head_last = l0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d0    <= '0;
      d1    <= '0;
      l0    <= 1'b0;
      l1    <= 1'b0;
      count <= 2'd0;
    end else if (push && pop) begin
      // head advances, count unchanged
      if (count == 2'd2) begin
        d0 <= d1;
        l0 <= l1;
        d1 <= push_data;
        l1 <= push_last;
      end else begin
        d0 <= push_data;
        l0 <= push_last;
      end
    end else if (push) begin
      if (count == 2'd0) begin
        d0 <= push_data;
        l0 <= push_last;
      end else begin
        d1 <= push_data;
        l1 <= push_last;
      end
      count <= count + 2'd1;
    end else if (pop) begin
      d0    <= d1;
      l0    <= l1;
      count <= count - 2'd1;
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Read-side FIFO controller: pops the FIFO and re-presents
// words as a framed valid/ready stream.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = fifo_pkg::DATA_WIDTH,
  parameter int PACKET_WORDS = 8,
  parameter int COUNT_BITS   = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  input  logic                  fifo_empty,
  output logic                  read_enable,
  output logic                  busy,
  fifo_reader_if.master         st
);

  rd_state_e             state, state_nx;
  logic                  in_flight;
  logic [COUNT_BITS-1:0] word_cnt;
  logic [1:0]            count;
  logic [2:0]            credit;
  logic                  pop;
  logic                  last_word;

  assign pop       = st.out_valid & st.out_ready;
  assign last_word = (word_cnt == COUNT_BITS'(PACKET_WORDS - 1));

  // widened before subtracting so the sum cannot wrap
  assign credit = {1'b0, count} + {2'b0, in_flight}
                - {2'b0, pop};

  assign read_enable = reset_n & (state == ACTIVE) & enable
                     & ~fifo_empty & (credit < 3'd2);

  assign st.out_valid = (count != 2'd0);
  assign busy         = (state != IDLE);

  stream_skid_buffer #(
    .DW (DATA_WIDTH)
  ) u_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (in_flight),
    .push_data (fifo_q),
    .push_last (last_word),
    .pop       (pop),
    .head_data (st.out_data),
    .head_last (st.out_last),
    .count     (count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_flight <= 1'b0;
      word_cnt  <= '0;
    end else begin
      state     <= state_nx;
      in_flight <= read_enable;
      if (in_flight) begin
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (enable) state_nx = ACTIVE;
      ACTIVE: if (!enable) state_nx = DRAIN;
      DRAIN: begin
        if (enable)
          state_nx = ACTIVE;
        else if (count == 2'd0 && !in_flight)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed + random bench for fifo_reader against a
// queue-based model of the FIFO and the output stream.
module tb_fifo_reader;
  import fifo_pkg::*;

  localparam int DW = 32;
  localparam int PW = 8;

  typedef struct {
    logic [DW-1:0] d;
    bit            l;
    int            c;
  } item_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [DW-1:0] fifo_q;
  logic          fifo_empty;
  logic          read_enable;
  logic          busy;

  fifo_reader_if #(.DW(DW)) sif ();

  fifo_reader #(
    .DATA_WIDTH   (DW),
    .PACKET_WORDS (PW),
    .COUNT_BITS   (3)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .fifo_q      (fifo_q),
    .fifo_empty  (fifo_empty),
    .read_enable (read_enable),
    .busy        (busy),
    .st          (sif.master)
  );

  always #5 clock = ~clock;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            ridx = 0;
  bit            en_prev = 0;
  bit            idle_m = 1;
  bit            stall_prev = 0;
  bit            force_e = 0;
  bit            re_seen = 0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] src[$];
  item_t         exp_q[$];

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One clock: sample at negedge, drive fifo_q after posedge
  task automatic tick();
    item_t         it;
    int            acc;
    int            occ;
    bit            exp_re;
    bit            exp_v;
    bit            nxt_idle;
    bit            did_re;
    logic [DW-1:0] w;
    w = $urandom;
    fifo_empty = force_e | (src.size() == 0);
    @(negedge clock);
    occ = exp_q.size();
    acc = (sif.out_valid === 1'b1 && sif.out_ready) ? 1 : 0;
    exp_re = en_prev && enable && !fifo_empty
             && (occ - acc < 2);
    exp_v = 0;
    if (occ > 0) exp_v = (exp_q[0].c + 2 <= cyc);
    chk("read_enable", read_enable, exp_re);
    chk("out_valid", sif.out_valid, exp_v);
    chk("busy", busy, !idle_m);
    if (stall_prev) chk("hold", sif.out_data, prev_data);
    if (acc == 1 && occ > 0) begin
      it = exp_q.pop_front();
      chk("data", sif.out_data, it.d);
      chk("last", sif.out_last, it.l);
    end
    nxt_idle = !enable
               && (idle_m || (!en_prev && occ == 0));
    stall_prev = (sif.out_valid === 1'b1) && !sif.out_ready;
    prev_data = sif.out_data;
    did_re = (read_enable === 1'b1);
    re_seen = did_re;
    if (did_re) begin
      if (src.size() > 0) w = src.pop_front();
      it.d = w;
      it.l = ((ridx % PW) == PW - 1);
      it.c = cyc;
      exp_q.push_back(it);
      ridx++;
    end
    en_prev = enable;
    idle_m = nxt_idle;
    @(posedge clock);
    #1;
    fifo_q = did_re ? w : DW'($urandom);
    cyc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_valid", sif.out_valid, 0);
    chk("rst_last", sif.out_last, 0);
    chk("rst_data", sif.out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_re", read_enable, 0);
    exp_q.delete();
    ridx = 0;
    en_prev = 0;
    idle_m = 1;
    stall_prev = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    reset_n = 1'b1;
    enable = 1'b0;
    sif.out_ready = 1'b0;
    fifo_empty = 1'b1;
    fifo_q = '0;
    #2;
    do_reset();

    // back-to-back 0x0..0xF
    for (int i = 0; i < 16; i++) src.push_back(DW'(i));
    enable = 1'b1;
    sif.out_ready = 1'b1;
    n = 0;
    repeat (22) begin
      tick();
      n += int'(re_seen);
    end
    chk("burst_reads", n, 16);

    // backpressure after 3 accepted words
    for (int i = 0; i < 16; i++) src.push_back(DW'(16 + i));
    n = 0;
    for (int k = 0; k < 20 && n < 3; k++) begin
      if (sif.out_valid === 1'b1) n++;
      tick();
    end
    chk("bp_accepted", n, 3);
    sif.out_ready = 1'b0;
    repeat (6) tick();
    chk("bp_stall_re", read_enable, 0);
    sif.out_ready = 1'b1;
    repeat (25) tick();

    // empty flag toggling
    for (int i = 0; i < 12; i++) src.push_back(DW'(32 + i));
    repeat (30) begin
      force_e = ~force_e;
      tick();
    end
    force_e = 0;

    // enable dropped right after a read
    for (int i = 0; i < 4; i++) src.push_back(DW'(48 + i));
    re_seen = 0;
    for (int k = 0; k < 5 && !re_seen; k++) tick();
    chk("drop_saw_re", re_seen, 1);
    enable = 1'b0;
    repeat (8) tick();
    chk("drop_idle", busy, 0);
    src.delete();

    // framing across an enable gap
    do_reset();
    for (int i = 0; i < 10; i++) src.push_back(DW'(64 + i));
    enable = 1'b1;
    for (int k = 0; k < 20 && ridx < 6; k++) tick();
    enable = 1'b0;
    repeat (5) tick();
    enable = 1'b1;
    repeat (15) tick();

    // reset with buffer full
    for (int i = 0; i < 12; i++) src.push_back(DW'(80 + i));
    sif.out_ready = 1'b0;
    repeat (5) tick();
    do_reset();
    sif.out_ready = 1'b1;
    repeat (25) tick();

    // random traffic
    repeat (400) begin
      if (src.size() < 4) src.push_back(DW'($urandom));
      enable = ($urandom_range(0, 9) != 0);
      sif.out_ready = ($urandom_range(0, 3) != 0);
      force_e = ($urandom_range(0, 4) == 0);
      tick();
    end
    enable = 1'b0;
    force_e = 0;
    sif.out_ready = 1'b1;
    repeat (8) tick();
    chk("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
